// File: rtl/tt_um_example_uart_tx.sv
// 8N1 UART transmitter in a TinyTapeout-style wrapper.
// A start strobe on uio_in[0] latches ui_in and serialises it onto uo_out[0].
`timescale 1ns/1ps
module tt_um_example_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned BAUD_W = 16;
    localparam int unsigned BIT_W  = 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic start_c;
    logic baud_wrap_c;
    logic unused_ok;

    assign start_c     = uio_in[0] & ena;
    assign baud_wrap_c = (baud_q == BAUD_LAST);
    assign unused_ok   = &{1'b0, uio_in[7:1]};

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update; state/bit advance on baud wrap
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (start_c) begin
                    state_d = START;
                    shift_d = ui_in;
                end
            end
            START: begin
                baud_d = baud_wrap_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_wrap_c) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                baud_d = baud_wrap_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_wrap_c) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == BIT_W'(7)) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                baud_d = baud_wrap_c ? '0 : baud_q + BAUD_W'(1);
                if (baud_wrap_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output flop inputs follow the upcoming state so pins change with it
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && baud_wrap_c;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign uo_out  = {5'b0, done_q, busy_q, tx_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_example_uart_tx.sv
// Directed self-checking bench for the UART transmitter at CLKS_PER_BIT=100.
`timescale 1ns/1ps
module tb_tt_um_example_uart_tx;

    localparam int unsigned CPB   = 100;
    localparam int          FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    tt_um_example_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive and sample 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns at the first cycle of the frame
    task automatic start_tx(input logic [7:0] d);
        ui_in     = d;
        uio_in[0] = 1'b1;
        tick();
        uio_in[0] = 1'b0;
        ui_in     = ~d;
    endtask

    // Observe one frame from its first cycle to FRAME+1; decodes mid-bit
    task automatic run_frame(input logic [7:0] data, input int hold_at,
                             input int ena_drop_at, input string tag);
        int         busy_cnt;
        int         done_cnt;
        int         k;
        logic [7:0] rx;
        logic [9:0] exp_bits;
        busy_cnt = 0;
        done_cnt = 0;
        rx       = 8'h00;
        exp_bits = {1'b1, data, 1'b0};
        for (int c = 0; c < FRAME + 2; c++) begin
            if (uo_out[1] && c <= FRAME) busy_cnt++;
            if (uo_out[2]) done_cnt++;
            if (c == 0)
                check_eq({tag, "_first"}, 32'(uo_out[2:0]), 32'b010);
            if ((c % CPB) == CPB / 2 && c < FRAME) begin
                k = c / CPB;
                check_eq($sformatf("%s_bit%0d", tag, k), 32'(uo_out[0]), 32'(exp_bits[k]));
                if (k >= 1 && k <= 8) rx[k-1] = uo_out[0];
            end
            if (c == FRAME - 1)
                check_eq({tag, "_last"}, 32'(uo_out[2:0]), 32'b011);
            if (c == FRAME)
                check_eq({tag, "_done"}, 32'(uo_out[2:0]), 32'b101);
            if (hold_at >= 0 && c == hold_at) begin
                uio_in[0] = 1'b1;
                ui_in     = 8'hFF;
            end
            if (hold_at >= 0 && c == hold_at + 1) uio_in[0] = 1'b0;
            if (c == ena_drop_at) ena = 1'b0;
            tick();
        end
        check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(FRAME));
        check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_rx"}, 32'(rx), 32'(data));
    endtask

    // Watch n cycles; expects the line idle high and not busy throughout
    task automatic idle_watch(input int n, input string tag);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            if (uo_out[1:0] != 2'b01) bad++;
            tick();
        end
        check_eq({tag, "_idle"}, 32'(bad), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("reset_uo_out", 32'(uo_out), 32'h01);
        check_eq("reset_uio_oe", 32'(uio_oe), 32'h00);
        check_eq("reset_uio_out", 32'(uio_out), 32'h00);
        rst = 1'b0;
        tick();
        check_eq("post_reset_uo_out", 32'(uo_out), 32'h01);

        // Basic frames
        ena = 1'b1;
        start_tx(8'h55);
        run_frame(8'h55, -1, -1, "f55");
        idle_watch(198, "f55_tail");
        start_tx(8'hA5);
        run_frame(8'hA5, -1, -1, "fA5");
        idle_watch(50, "fA5_tail");

        // Start during busy is ignored and not queued
        start_tx(8'h55);
        run_frame(8'h55, 500, -1, "busy_start");
        idle_watch(200, "busy_start_tail");

        // ena gating: strobe with ena=0 and unused uio bits set
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'hFF;
        tick();
        uio_in = 8'h00;
        idle_watch(20, "ena_off");
        check_eq("ena_off_uo_out", 32'(uo_out), 32'h01);

        // ena dropped mid-frame still completes
        ena = 1'b1;
        start_tx(8'hC3);
        run_frame(8'hC3, -1, 300, "ena_drop");
        ena = 1'b1;
        idle_watch(10, "ena_drop_tail");

        // Reset mid-frame aborts immediately
        start_tx(8'h81);
        for (int i = 0; i < 350; i++) tick();
        check_eq("mid_busy", 32'(uo_out[1]), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("mid_reset_uo_out", 32'(uo_out), 32'h01);
        rst = 1'b0;
        idle_watch(20, "mid_reset");
        start_tx(8'h3C);
        run_frame(8'h3C, -1, -1, "f3C");
        idle_watch(10, "f3C_tail");

        // Start held high: re-triggers after one idle cycle
        ui_in     = 8'h0F;
        uio_in[0] = 1'b1;
        tick();
        run_frame(8'h0F, -1, -1, "hold");
        check_eq("hold_retrigger", 32'(uo_out[2:0]), 32'b010);
        uio_in[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("final_uo_out", 32'(uo_out), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
